// File: rtl/nq_pipe_chain_pkg.sv
// nq_pipe_chain_pkg
// Shared definitions for the NanoQuarter decode->execute pipeline chain.
// Holds the default payload width, the helper that sizes the occupancy
// counter, and the layout of the decoded-instruction bundle so that the
// decode stage (producer) and execute/memory stages (consumers) pack and
// unpack the opaque payload identically.
package nq_pipe_chain_pkg;

    localparam int NQ_PAYLOAD_W = 64;

    // Bit offsets of the decoded bundle, LSB first.
    localparam int NQ_F_REGWRITE = 0;
    localparam int NQ_F_MEMWRITE = 1;
    localparam int NQ_F_MEMREAD  = 2;
    localparam int NQ_F_BNE      = 3;
    localparam int NQ_F_JMP      = 4;
    localparam int NQ_F_REG2DATA = 5;   // 8 bits
    localparam int NQ_F_REG1DATA = 13;  // 8 bits
    localparam int NQ_F_BOFF     = 21;  // 8 bits
    localparam int NQ_F_IDATA    = 29;  // 8 bits
    localparam int NQ_F_SHAMT    = 37;  // 3 bits
    localparam int NQ_F_FUNCT    = 40;  // 3 bits
    localparam int NQ_F_OP       = 43;  // 4 bits
    localparam int NQ_F_PC       = 47;  // 16 bits

    // Same layout as the offsets above; first member is the MSB.
    typedef struct packed {
        logic        spare;
        logic [15:0] pc;
        logic [3:0]  op;
        logic [2:0]  funct;
        logic [2:0]  shamt;
        logic [7:0]  idata;
        logic [7:0]  boff;
        logic [7:0]  reg1data;
        logic [7:0]  reg2data;
        logic        jmp;
        logic        bne;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
    } nq_bundle_t;

    // Occupancy counts up to STAGES slots plus an optional skid entry.
    function automatic int nq_occ_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/nq_pipe_slot.sv
// nq_pipe_slot
// One valid+data register of the pipeline chain (also used as the skid entry).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears valid only)
//   load            take in_valid/in_data at the next edge
//   flush           clear valid at the next edge (overrides load)
//   in_valid/in_data  upstream payload
//   valid_next      valid value that will be registered at the next edge
//   out_valid/out_data  held payload
module nq_pipe_slot
    import nq_pipe_chain_pkg::*;
#(
    parameter int DATA_W = NQ_PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid_next,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Data only changes when a real payload is loaded, so a held payload
    // is guaranteed stable until it moves on.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid_next = valid_d;
    assign out_valid  = valid_q;
    assign out_data   = data_q;

endmodule

// File: rtl/nq_pipe_chain.sv
// nq_pipe_chain
// Parametrised valid/ready register chain carrying the decoded bundle from
// decode to execute/memory. STAGES slots with a combinational ready chain
// (bubbles collapse), synchronous flush, and an optional one-entry input skid
// buffer (SKID=1) so in_ready is driven from a flop.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    upstream handshake and payload
//   flush                    drop every held payload at the next edge
//   out_valid/out_ready/out_data downstream handshake and payload
//   occupancy                registered count of valid slots plus skid entry
// Optional macro NQ_PIPE_PERF_CNT_EN adds saturating 32-bit stall_cnt and
// bubble_cnt outputs; without it those ports and counters do not exist.
module nq_pipe_chain
    import nq_pipe_chain_pkg::*;
#(
    parameter int DATA_W = NQ_PAYLOAD_W,
    parameter int STAGES = 2,
    parameter int SKID   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [nq_occ_width(STAGES)-1:0]   occupancy
`ifdef NQ_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                       stall_cnt,
    output logic [31:0]                       bubble_cnt
`endif
);

    localparam int OCC_W = nq_occ_width(STAGES);

    logic [STAGES-1:0] slot_v;
    logic [STAGES-1:0] slot_v_next;
    logic [DATA_W-1:0] slot_d [STAGES];
    logic [STAGES:0]   adv;
    logic              accept;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              skid_v;
    logic              skid_v_next;
    logic              ready_en_q;
    logic              ready_en_d;
    logic [OCC_W-1:0]  occupancy_q;
    logic [OCC_W-1:0]  occupancy_d;

    // adv[k] means slot k loads this edge: it is empty or its successor loads.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !slot_v[k] | adv[k+1];
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load;
            logic              skid_in_valid;
            logic [DATA_W-1:0] skid_d;

            // in_ready only looks at flops (plus the flush override); a payload
            // accepted while slot 0 stalls is parked in the skid entry.
            assign in_ready      = ready_en_q & !flush & !skid_v;
            assign accept        = in_valid & in_ready;
            assign skid_load     = !skid_v | adv[0];
            assign skid_in_valid = !skid_v & accept & !adv[0];
            assign src_valid     = skid_v | accept;
            assign src_data      = skid_v ? skid_d : in_data;

            nq_pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk        (clk),
                .rst        (rst),
                .load       (skid_load),
                .flush      (flush),
                .in_valid   (skid_in_valid),
                .in_data    (in_data),
                .valid_next (skid_v_next),
                .out_valid  (skid_v),
                .out_data   (skid_d)
            );
        end else begin : g_no_skid
            assign in_ready    = ready_en_q & !flush & adv[0];
            assign accept      = in_valid & in_ready;
            assign src_valid   = accept;
            assign src_data    = in_data;
            assign skid_v      = 1'b0;
            assign skid_v_next = 1'b0;
        end
    endgenerate

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic              up_v;
        logic [DATA_W-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = src_valid;
            assign up_d = src_data;
        end else begin : g_body
            assign up_v = slot_v[k-1];
            assign up_d = slot_d[k-1];
        end

        nq_pipe_slot #(.DATA_W(DATA_W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (adv[k]),
            .flush      (flush),
            .in_valid   (up_v),
            .in_data    (up_d),
            .valid_next (slot_v_next[k]),
            .out_valid  (slot_v[k]),
            .out_data   (slot_d[k])
        );
    end

    // Occupancy reflects the state the slots will hold after this edge.
    always_comb begin
        occupancy_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy_d = occupancy_d + OCC_W'(slot_v_next[k]);
        end
        occupancy_d = occupancy_d + OCC_W'(skid_v_next);
    end

    // ready_en holds in_ready low until the first edge after reset release.
    assign ready_en_d = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q  <= 1'b0;
            occupancy_q <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign out_valid = slot_v[STAGES-1];
    assign out_data  = slot_d[STAGES-1];
    assign occupancy = occupancy_q;

`ifdef NQ_PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    // Saturating counters; flush deliberately has no effect on them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!out_valid && (occupancy_q != '0) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_nq_pipe_chain.sv
// tb_nq_pipe_chain
// Drives three chains in parallel (STAGES=2/SKID=0, STAGES=3/SKID=0,
// STAGES=2/SKID=1) with shared inputs and checks each against a payload-queue
// reference model that tracks every in-flight payload and its slot position.
module tb_nq_pipe_chain;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;

    logic          in_ready_o  [3];
    logic          out_valid_o [3];
    logic [DW-1:0] out_data_o  [3];
    logic [7:0]    occ_o       [3];
    logic [1:0]    occ0;
    logic [2:0]    occ1;
    logic [1:0]    occ2;
`ifdef NQ_PIPE_PERF_CNT_EN
    logic [31:0]   stall_o     [3];
    logic [31:0]   bubble_o    [3];
`endif

    assign occ_o[0] = {6'd0, occ0};
    assign occ_o[1] = {5'd0, occ1};
    assign occ_o[2] = {6'd0, occ2};

    nq_pipe_chain #(.DATA_W(DW), .STAGES(2), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_o[0]),
        .out_ready(out_ready), .out_data(out_data_o[0]), .occupancy(occ0)
`ifdef NQ_PIPE_PERF_CNT_EN
        , .stall_cnt(stall_o[0]), .bubble_cnt(bubble_o[0])
`endif
    );

    nq_pipe_chain #(.DATA_W(DW), .STAGES(3), .SKID(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_o[1]),
        .out_ready(out_ready), .out_data(out_data_o[1]), .occupancy(occ1)
`ifdef NQ_PIPE_PERF_CNT_EN
        , .stall_cnt(stall_o[1]), .bubble_cnt(bubble_o[1])
`endif
    );

    nq_pipe_chain #(.DATA_W(DW), .STAGES(2), .SKID(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_o[2]),
        .out_ready(out_ready), .out_data(out_data_o[2]), .occupancy(occ2)
`ifdef NQ_PIPE_PERF_CNT_EN
        , .stall_cnt(stall_o[2]), .bubble_cnt(bubble_o[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: per instance, an ordered list of in-flight payloads
    // with their slot index (STAGES-1 = output slot, -1 = skid entry).
    int            stg [3] = '{2, 3, 2};
    int            skd [3] = '{0, 0, 1};
    logic [DW-1:0] md  [3][8];
    int            mp  [3][8];
    int            mn  [3];
    int            m_stall  [3];
    int            m_bubble [3];
    logic          m_alive;

    int total;
    int bad;

    function automatic logic exp_in_ready(int i);
        if (!m_alive || flush) return 1'b0;
        if (skd[i] != 0) return (mn[i] != stg[i] + 1);
        return (mn[i] < stg[i]) || out_ready;
    endfunction

    function automatic logic exp_out_valid(int i);
        return (mn[i] > 0) && (mp[i][0] == stg[i] - 1);
    endfunction

    task automatic resetModel();
        m_alive = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mn[i]       = 0;
            m_stall[i]  = 0;
            m_bubble[i] = 0;
        end
    endtask

    task automatic modelEdge();
        for (int i = 0; i < 3; i++) begin
            logic acc;
            logic dlv;
            logic ov;
            int   lim;
            int   np;
            ov  = exp_out_valid(i);
            acc = in_valid & exp_in_ready(i);
            dlv = ov & out_ready;
            if (ov && !out_ready) m_stall[i]++;
            if (!ov && mn[i] != 0) m_bubble[i]++;
            if (flush) begin
                mn[i] = 0;
            end else begin
                if (dlv) begin
                    for (int j = 1; j < mn[i]; j++) begin
                        md[i][j-1] = md[i][j];
                        mp[i][j-1] = mp[i][j];
                    end
                    mn[i]--;
                end
                // Each payload moves one slot forward unless the one ahead
                // still occupies the slot in front of it.
                lim = stg[i] - 1;
                for (int j = 0; j < mn[i]; j++) begin
                    np = mp[i][j] + 1;
                    if (np > lim) np = lim;
                    mp[i][j] = np;
                    lim = np - 1;
                end
                if (acc) begin
                    md[i][mn[i]] = in_data;
                    mp[i][mn[i]] = (lim >= 0) ? 0 : -1;
                    mn[i]++;
                end
            end
        end
        m_alive = 1'b1;
    endtask

    task automatic checkVal(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s[%0d]: observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            checkVal("in_ready", i, 32'(in_ready_o[i]), 32'(exp_in_ready(i)));
            checkVal("out_valid", i, 32'(out_valid_o[i]), 32'(exp_out_valid(i)));
            if (exp_out_valid(i)) begin
                checkVal("out_data", i, 32'(out_data_o[i]), 32'(md[i][0]));
            end
            checkVal("occupancy", i, 32'(occ_o[i]), 32'(mn[i]));
`ifdef NQ_PIPE_PERF_CNT_EN
            checkVal("stall_cnt", i, stall_o[i], 32'(m_stall[i]));
            checkVal("bubble_cnt", i, bubble_o[i], 32'(m_bubble[i]));
`endif
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [DW-1:0] id, input logic orr, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        flush     = fl;
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge();
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkVal("ready_after_rst", i, 32'(in_ready_o[i]), 32'd1);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        resetModel();

        // Power-on reset.
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput();
        releaseReset();

        // Streaming at full rate.
        $display("[TB] streaming");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, DW'(16'h11 + k), 1'b1, 1'b0);
        end
        #1;
        checkVal("stream_occ", 0, 32'(occ_o[0]), 32'd2);
        checkVal("stream_occ", 1, 32'(occ_o[1]), 32'd3);
        checkVal("stream_head", 0, 32'(out_data_o[0]), 32'h17);
        checkVal("stream_head", 1, 32'(out_data_o[1]), 32'h16);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: fill, stall five cycles, release.
        $display("[TB] backpressure");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(16'h21 + k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 16'h24, 1'b0, 1'b0);
        #1;
        checkVal("bp_ready", 1, 32'(in_ready_o[1]), 32'd0);
        checkVal("bp_head", 1, 32'(out_data_o[1]), 32'h21);
        checkVal("bp_occ", 1, 32'(occ_o[1]), 32'd3);
        checkVal("skid_occ", 2, 32'(occ_o[2]), 32'd3);
        checkVal("skid_ready", 2, 32'(in_ready_o[2]), 32'd0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Bubble collapse.
        $display("[TB] bubble collapse");
        applyStimulus(1'b1, 16'h31, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h32, 1'b0, 1'b0);
        #1;
        checkVal("bubble_occ", 1, 32'(occ_o[1]), 32'd2);
        checkVal("bubble_head", 1, 32'(out_data_o[1]), 32'h31);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush with two held payloads and a pending input.
        $display("[TB] flush");
        applyStimulus(1'b1, 16'h41, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h42, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h43, 1'b0, 1'b1);
        #1;
        checkVal("flush_ready", 0, 32'(in_ready_o[0]), 32'd0);
        checkVal("flush_occ", 0, 32'(occ_o[0]), 32'd0);
        checkVal("flush_valid", 1, 32'(out_valid_o[1]), 32'd0);
        applyStimulus(1'b1, 16'h44, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset with payloads in flight.
        $display("[TB] reset mid-operation");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(16'h51 + k), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        resetModel();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkVal("rst_valid", i, 32'(out_valid_o[i]), 32'd0);
            checkVal("rst_occ", i, 32'(occ_o[i]), 32'd0);
            checkVal("rst_ready", i, 32'(in_ready_o[i]), 32'd0);
`ifdef NQ_PIPE_PERF_CNT_EN
            checkVal("rst_stall", i, stall_o[i], 32'd0);
`endif
        end
        @(posedge clk);
        releaseReset();

        // Randomised traffic.
        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, DW'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
